// File: rtl/rv32im_dmem_if.sv
// Memory-port bundle between the rv32im LSU (master) and the data memory (slave).
// Handshake: a request is taken when enable_i is high and the slave is not busy; the slave answers with a one-cycle ready_o pulse carrying rdata_o and err_o.
interface rv32im_dmem_if;
    logic        enable_i;
    logic [31:0] addr_i;
    logic [3:0]  wr_mask_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output enable_i, addr_i, wr_mask_i, wdata_i,
        input  rdata_o, ready_o, err_o, busy_o
    );

    modport slave (
        input  enable_i, addr_i, wr_mask_i, wdata_i,
        output rdata_o, ready_o, err_o, busy_o
    );
endinterface

// File: rtl/rv32im_dmem.sv
// Word-organised data memory behind the rv32im LSU: realigns right-justified store data onto
// byte lanes, checks mask/address legality, and answers after WAIT_STATES extra cycles.
module rv32im_dmem #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    rv32im_dmem_if.slave     bus,
    output logic [1:0]       state_o
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        commit;

    logic [31:0] addr_q;
    logic [3:0]  mask_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic [31:0]      acc_addr;
    logic [3:0]       acc_mask;
    logic [31:0]      acc_wdata;
    logic [31:0]      acc_offset;
    logic [29:0]      word_idx;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             out_of_range;
    logic             acc_err;
    logic [31:0]      shifted;
    logic [31:0]      old_word;
    logic [31:0]      merged;
    logic [31:0]      resp_word;

    function automatic logic legal_pair(input logic [3:0] m, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (m)
            4'b0000: ok = 1'b1;
            4'b0001: ok = (a == 2'b00);
            4'b0010: ok = (a == 2'b01);
            4'b0100: ok = (a == 2'b10);
            4'b1000: ok = (a == 2'b11);
            4'b0011: ok = (a == 2'b00);
            4'b1100: ok = (a == 2'b10);
            4'b1111: ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (bus.enable_i) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the access commits on the accept edge, so it must use the live bus values.
    always_comb begin
        acc_addr  = (state_q == IDLE) ? bus.addr_i    : addr_q;
        acc_mask  = (state_q == IDLE) ? bus.wr_mask_i : mask_q;
        acc_wdata = (state_q == IDLE) ? bus.wdata_i   : wdata_q;

        acc_offset   = acc_addr - BASE_ADDR;
        word_idx     = acc_offset[31:2];
        lane         = acc_offset[1:0];
        idx          = word_idx[IDX_W-1:0];
        out_of_range = (acc_addr < BASE_ADDR) || (word_idx >= 30'(DEPTH));
        acc_err      = out_of_range || !legal_pair(acc_mask, lane);

        shifted  = acc_wdata << {lane, 3'b000};
        old_word = out_of_range ? 32'h0 : mem[idx];
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = acc_mask[i] ? shifted[8*i +: 8] : old_word[8*i +: 8];
        end

        if (acc_err) begin
            resp_word = 32'h0;
        end else if (acc_mask != 4'b0000) begin
            resp_word = merged;
        end else begin
            resp_word = old_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            mask_q  <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.enable_i) begin
                addr_q  <= bus.addr_i;
                mask_q  <= bus.wr_mask_i;
                wdata_q <= bus.wdata_i;
            end
            if (commit) begin
                rdata_q <= resp_word;
                err_q   <= acc_err;
            end
        end
    end

    // Storage is never cleared; reset only suppresses a commit landing on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_ni && commit && !acc_err && (acc_mask != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[idx][8*i +: 8] <= shifted[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready_o = (state_q == RESP);
    assign bus.err_o   = (state_q == RESP) && err_q;
    assign bus.rdata_o = rdata_q;
    assign bus.busy_o  = (state_q != IDLE);
    assign state_o     = state_q;

endmodule
